// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 LSB-first UART transmitter with gapless back-to-back frames
//   clk      : system clock, rising edge
//   reset    : asynchronous active-low reset
//   wr_en    : push wr_data into the FIFO this cycle
//   wr_data  : byte to transmit
//   full     : FIFO holds FIFO_DEPTH bytes
//   count    : bytes waiting in the FIFO (not counting the byte being shifted out)
//   busy     : a frame is in progress
//   overflow : sticky, a write was dropped because the FIFO was full
//   tx       : serial output, idle high
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 2604,
   parameter int FIFO_DEPTH   = 4,
   parameter int PTR_W        = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [7:0]       wr_data,
   output logic             full,
   output logic [PTR_W:0]   count,
   output logic             busy,
   output logic             overflow,
   output logic             tx
);
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t state, state_d;
   logic [7:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [7:0] shift, shift_d;
   logic [BW-1:0] baud, baud_d;
   logic [2:0] bit_idx, bit_idx_d;
   logic tx_d, bit_end, pop, push;
   assign full    = count == (PTR_W+1)'(FIFO_DEPTH);
   assign busy    = state != IDLE;
   assign bit_end = baud == BW'(CLKS_PER_BIT - 1);
   // A pop happens when idle or at the last cycle of a stop bit, so frames chain without a gap.
   assign pop     = count != '0 && (state == IDLE || (state == STOP && bit_end));
   // A write while full still fits if the same edge frees a slot.
   assign push    = wr_en && (!full || pop);
   always_comb begin
      state_d   = state;
      shift_d   = shift;
      bit_idx_d = bit_idx;
      baud_d    = bit_end ? '0 : baud + 1'b1;
      case (state)
         IDLE:  baud_d = '0;
         START: if (bit_end) begin
            state_d   = DATA;
            bit_idx_d = '0;
         end
         DATA:  if (bit_end) begin
            shift_d   = shift >> 1;
            bit_idx_d = bit_idx + 3'd1;
            if (bit_idx == 3'd7) state_d = STOP;
         end
         STOP:  if (bit_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (pop) begin
         state_d = START;
         shift_d = mem[rd_ptr];
         baud_d  = '0;
      end
      // tx is registered from the next state so the line has no combinational path from wr_en.
      tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         shift    <= '0;
         baud     <= '0;
         bit_idx  <= '0;
         tx       <= 1'b1;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         state   <= state_d;
         shift   <= shift_d;
         baud    <= baud_d;
         bit_idx <= bit_idx_d;
         tx      <= tx_d;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop) count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         if (wr_en && !push) overflow <= 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo (CLKS_PER_BIT=4, FIFO_DEPTH=4)
module tb_uart_tx_fifo;
   localparam int CPB = 4;
   logic clk = 1'b0, reset = 1'b1, wr_en = 1'b0;
   logic [7:0] wr_data = 'x;
   logic full, busy, overflow, tx;
   logic [2:0] count;
   int vectors = 0, miscompares = 0;

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PTR_W(2)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
      .full(full), .count(count), .busy(busy), .overflow(overflow), .tx(tx)
   );

   always #20 clk = ~clk;

   // Expected line level i cycles into a frame carrying d: start 0, d LSB first, stop 1.
   function automatic logic frame_bit(input logic [7:0] d, input int i);
      logic [9:0] f;
      f = {1'b1, d, 1'b0};
      return f[i / CPB];
   endfunction

   task automatic pulse_reset;
      @(negedge clk);
      reset = 1'b0;
      wr_en = 1'b0;
      wr_data = 'x;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset;
      #1 reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if (tx !== 1'b1 || busy !== 1'b0 || count !== 3'd0 || full !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset[%0d]: tx=%b busy=%b count=%0d full=%b ovf=%b, want 1 0 0 0 0",
                     i, tx, busy, count, full, overflow);
         end
      end
      reset = 1'b1;
   endtask

   task automatic test_single;
      logic e;
      @(negedge clk);
      wr_en = 1'b1;
      wr_data = 8'hA5;
      for (int c = 0; c <= 41; c++) begin
         @(negedge clk);
         wr_en = 1'b0;
         wr_data = 'x;
         if (c == 0) begin
            vectors++;
            if (count !== 3'd1 || tx !== 1'b1 || busy !== 1'b0) begin
               miscompares++;
               $display("FAIL single_write: count=%0d tx=%b busy=%b, want 1 1 0", count, tx, busy);
            end
         end else if (c <= 40) begin
            e = frame_bit(8'hA5, c - 1);
            vectors++;
            if (tx !== e || busy !== 1'b1) begin
               miscompares++;
               $display("FAIL single_tx[%0d]: tx=%b busy=%b, want %b 1", c, tx, busy, e);
            end
         end else begin
            vectors++;
            if (tx !== 1'b1 || busy !== 1'b0 || count !== 3'd0) begin
               miscompares++;
               $display("FAIL single_end: tx=%b busy=%b count=%0d, want 1 0 0", tx, busy, count);
            end
         end
      end
   endtask

   task automatic test_overflow;
      logic e;
      @(negedge clk);
      wr_en = 1'b1;
      wr_data = 8'h01;
      for (int c = 0; c <= 201; c++) begin
         @(negedge clk);
         if (c < 5) wr_data = 8'(c + 2);
         else begin
            wr_en = 1'b0;
            wr_data = 'x;
         end
         if (c == 4) begin
            vectors++;
            if (full !== 1'b1 || overflow !== 1'b0) begin
               miscompares++;
               $display("FAIL ovf_full: full=%b ovf=%b, want 1 0", full, overflow);
            end
         end
         if (c == 5) begin
            vectors++;
            if (full !== 1'b1 || overflow !== 1'b1 || count !== 3'd4) begin
               miscompares++;
               $display("FAIL ovf_drop: full=%b ovf=%b count=%0d, want 1 1 4", full, overflow, count);
            end
         end
         if (c >= 1 && c <= 200) begin
            e = frame_bit(8'((c - 1) / 40 + 1), (c - 1) % 40);
            vectors++;
            if (tx !== e || busy !== 1'b1) begin
               miscompares++;
               $display("FAIL ovf_tx[%0d]: tx=%b busy=%b, want %b 1", c, tx, busy, e);
            end
         end
         if (c == 201) begin
            vectors++;
            if (tx !== 1'b1 || busy !== 1'b0 || count !== 3'd0 || overflow !== 1'b1) begin
               miscompares++;
               $display("FAIL ovf_end: tx=%b busy=%b count=%0d ovf=%b, want 1 0 0 1",
                        tx, busy, count, overflow);
            end
         end
      end
   endtask

   task automatic test_full_write_at_stop;
      pulse_reset();
      wr_en = 1'b1;
      wr_data = 8'h11;
      for (int c = 0; c <= 41; c++) begin
         @(negedge clk);
         if (c < 4) wr_data = 8'(8'h12 + c);
         else if (c == 40) begin
            wr_en = 1'b1;
            wr_data = 8'h16;
         end else begin
            wr_en = 1'b0;
            wr_data = 'x;
         end
         if (c == 40) begin
            vectors++;
            if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b0 || tx !== 1'b1) begin
               miscompares++;
               $display("FAIL fullstop_pre: count=%0d full=%b ovf=%b tx=%b, want 4 1 0 1",
                        count, full, overflow, tx);
            end
         end
         if (c == 41) begin
            vectors++;
            if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b0 || tx !== 1'b0) begin
               miscompares++;
               $display("FAIL fullstop_post: count=%0d full=%b ovf=%b tx=%b, want 4 1 0 0",
                        count, full, overflow, tx);
            end
         end
      end
      wr_en = 1'b0;
      wr_data = 'x;
   endtask

   task automatic test_reset_mid_frame;
      pulse_reset();
      wr_en = 1'b1;
      wr_data = 8'h3C;
      for (int c = 0; c <= 10; c++) begin
         @(negedge clk);
         wr_en = 1'b0;
         wr_data = 'x;
      end
      vectors++;
      if (tx !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL midreset_pre: tx=%b busy=%b, want 0 1", tx, busy);
      end
      reset = 1'b0;
      #1;
      vectors++;
      if (tx !== 1'b1 || busy !== 1'b0 || count !== 3'd0) begin
         miscompares++;
         $display("FAIL midreset_async: tx=%b busy=%b count=%0d, want 1 0 0", tx, busy, count);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         vectors++;
         if (tx !== 1'b1 || busy !== 1'b0 || count !== 3'd0) begin
            miscompares++;
            $display("FAIL midreset_idle[%0d]: tx=%b busy=%b count=%0d, want 1 0 0", c, tx, busy, count);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic e;
      @(negedge clk);
      wr_en = 1'b1;
      wr_data = 8'hFF;
      for (int c = 0; c <= 81; c++) begin
         @(negedge clk);
         if (c == 0) wr_data = 8'h00;
         else begin
            wr_en = 1'b0;
            wr_data = 'x;
         end
         if (c >= 1 && c <= 80) begin
            e = c <= 40 ? frame_bit(8'hFF, c - 1) : frame_bit(8'h00, c - 41);
            vectors++;
            if (tx !== e || busy !== 1'b1) begin
               miscompares++;
               $display("FAIL b2b_tx[%0d]: tx=%b busy=%b, want %b 1", c, tx, busy, e);
            end
         end
         if (c == 81) begin
            vectors++;
            if (tx !== 1'b1 || busy !== 1'b0 || count !== 3'd0) begin
               miscompares++;
               $display("FAIL b2b_end: tx=%b busy=%b count=%0d, want 1 0 0", tx, busy, count);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_full_write_at_stop();
      test_reset_mid_frame();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
